// File: rtl/id_stage.sv
// id_stage: MIPS-style decode stage with a one-entry hold slot, a registered
// output slot towards execute, and a pending-write scoreboard for RAW/WAW stalls.
module id_stage (
  input  logic        id_stage_clk,
  input  logic        id_stage_rst_n,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic [4:0]  rf_read1,
  output logic [4:0]  rf_read2,
  input  logic [31:0] rf_data1,
  input  logic [31:0] rf_data2,
  input  logic        wb_we,
  input  logic [4:0]  wb_id,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_dest,
  output logic        ex_we,
  output logic [5:0]  ex_opcode,
  output logic [5:0]  ex_funct,
  output logic [4:0]  ex_shamt,
  output logic [31:0] ex_pc,
  output logic        ex_illegal,
  output logic        o_dbg_state,
  output logic [31:0] o_dbg_pend
);

  // Handshake rule: a transfer happens on a rising edge where valid and ready
  // are both high; a ready never depends on the valid of its own interface.
  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} hold_state_t;

  hold_state_t r_state, w_state_next;
  logic [31:0] r_hold_instr, r_hold_pc;
  logic [31:0] r_pend, w_pend_next;

  logic        r_ex_valid, r_ex_we, r_ex_illegal;
  logic [31:0] r_ex_rs_data, r_ex_rt_data, r_ex_imm, r_ex_pc;
  logic [4:0]  r_ex_dest, r_ex_shamt;
  logic [5:0]  r_ex_opcode, r_ex_funct;

  logic        w_hold_valid, w_fetch, w_issue, w_hazard;
  logic [5:0]  w_opcode;
  logic [4:0]  w_rs, w_rt, w_rd, w_dest;
  logic [15:0] w_imm16;
  logic        w_we_raw, w_we, w_use_rs, w_use_rt, w_illegal;
  logic [31:0] w_imm, w_rs_data, w_rt_data;
  logic        w_wb_rs, w_wb_rt, w_wb_dest;

  assign w_hold_valid = (r_state == S_FULL);
  assign w_opcode     = r_hold_instr[31:26];
  assign w_rs         = r_hold_instr[25:21];
  assign w_rt         = r_hold_instr[20:16];
  assign w_rd         = r_hold_instr[15:11];
  assign w_imm16      = r_hold_instr[15:0];

  assign rf_read1 = w_rs;
  assign rf_read2 = w_rt;

  always_comb begin
    w_dest    = 5'd0;
    w_we_raw  = 1'b0;
    w_use_rs  = 1'b0;
    w_use_rt  = 1'b0;
    w_illegal = 1'b0;
    case (w_opcode)
      6'h00: begin
        w_dest   = w_rd;
        w_we_raw = 1'b1;
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
      end
      6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23: begin
        w_dest   = w_rt;
        w_we_raw = 1'b1;
        w_use_rs = 1'b1;
      end
      6'h2B, 6'h04, 6'h05: begin
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
      end
      6'h02: ;
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_imm = {{16{w_imm16[15]}}, w_imm16};
    case (w_opcode)
      6'h0C, 6'h0D, 6'h0E: w_imm = {16'h0000, w_imm16};
      6'h0F:               w_imm = {w_imm16, 16'h0000};
      default:             ;
    endcase
  end

  // Register 0 is hardwired, so a write to it is architecturally a no-op.
  assign w_we = w_we_raw & (w_dest != 5'd0);

  assign w_wb_rs   = wb_we & (wb_id == w_rs);
  assign w_wb_rt   = wb_we & (wb_id == w_rt);
  assign w_wb_dest = wb_we & (wb_id == w_dest);

  assign w_hazard = (w_use_rs & r_pend[w_rs]   & ~w_wb_rs)
                  | (w_use_rt & r_pend[w_rt]   & ~w_wb_rt)
                  | (w_we     & r_pend[w_dest] & ~w_wb_dest);

  assign w_issue  = w_hold_valid & ~w_hazard & (~r_ex_valid | ex_ready) & ~flush;
  assign if_ready = (~w_hold_valid | w_issue) & ~flush;
  assign w_fetch  = if_valid & if_ready;

  assign w_rs_data = (w_rs == 5'd0) ? 32'h0 : (w_wb_rs ? wb_data : rf_data1);
  assign w_rt_data = (w_rt == 5'd0) ? 32'h0 : (w_wb_rt ? wb_data : rf_data2);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_EMPTY: if (w_fetch) w_state_next = S_FULL;
      S_FULL: begin
        if (flush)                  w_state_next = S_EMPTY;
        else if (w_issue && !w_fetch) w_state_next = S_EMPTY;
      end
      default: w_state_next = S_EMPTY;
    endcase
  end

  // A same-cycle issue to a register wins over its writeback clear.
  always_comb begin
    w_pend_next = r_pend;
    if (wb_we) w_pend_next[wb_id] = 1'b0;
    if (flush && r_ex_valid && !ex_ready && r_ex_we) w_pend_next[r_ex_dest] = 1'b0;
    if (w_issue && w_we) w_pend_next[w_dest] = 1'b1;
    w_pend_next[0] = 1'b0;
  end

  always_ff @(posedge id_stage_clk or negedge id_stage_rst_n) begin
    if (!id_stage_rst_n) begin
      r_state      <= S_EMPTY;
      r_hold_instr <= 32'h0;
      r_hold_pc    <= 32'h0;
      r_pend       <= 32'h0;
    end else begin
      r_state <= w_state_next;
      r_pend  <= w_pend_next;
      if (w_fetch) begin
        r_hold_instr <= if_instr;
        r_hold_pc    <= if_pc;
      end
    end
  end

  always_ff @(posedge id_stage_clk or negedge id_stage_rst_n) begin
    if (!id_stage_rst_n) begin
      r_ex_valid   <= 1'b0;
      r_ex_we      <= 1'b0;
      r_ex_illegal <= 1'b0;
      r_ex_rs_data <= 32'h0;
      r_ex_rt_data <= 32'h0;
      r_ex_imm     <= 32'h0;
      r_ex_pc      <= 32'h0;
      r_ex_dest    <= 5'd0;
      r_ex_shamt   <= 5'd0;
      r_ex_opcode  <= 6'd0;
      r_ex_funct   <= 6'd0;
    end else if (w_issue) begin
      r_ex_valid   <= 1'b1;
      r_ex_we      <= w_we;
      r_ex_illegal <= w_illegal;
      r_ex_rs_data <= w_rs_data;
      r_ex_rt_data <= w_rt_data;
      r_ex_imm     <= w_imm;
      r_ex_pc      <= r_hold_pc;
      r_ex_dest    <= w_dest;
      r_ex_shamt   <= r_hold_instr[10:6];
      r_ex_opcode  <= w_opcode;
      r_ex_funct   <= r_hold_instr[5:0];
    end else if (flush || ex_ready) begin
      r_ex_valid <= 1'b0;
    end
  end

  assign ex_valid    = r_ex_valid;
  assign ex_we       = r_ex_we;
  assign ex_illegal  = r_ex_illegal;
  assign ex_rs_data  = r_ex_rs_data;
  assign ex_rt_data  = r_ex_rt_data;
  assign ex_imm      = r_ex_imm;
  assign ex_pc       = r_ex_pc;
  assign ex_dest     = r_ex_dest;
  assign ex_shamt    = r_ex_shamt;
  assign ex_opcode   = r_ex_opcode;
  assign ex_funct    = r_ex_funct;
  assign o_dbg_state = r_state;
  assign o_dbg_pend  = r_pend;

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 The block SHALL have ports, one per line: name  direction  width  meaning.
REQ-002 id_stage_clk  in  1  sole clock, all state updates on rising edge.
REQ-003 id_stage_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 if_valid/if_ready  in/out  1/1  fetch handshake; if_instr in 32, if_pc in 32.
REQ-005 rf_read1/rf_read2  out  5/5  register-file read ids (rs, rt); rf_data1/rf_data2  in  32/32  asynchronous read data.
REQ-006 wb_we  in  1, wb_id  in  5, wb_data  in  32  writeback bus, same signals that drive the register-file write port.
REQ-007 flush  in  1  discard held and unaccepted instructions.
REQ-008 ex_valid  out  1, ex_ready  in  1  execute handshake.
REQ-009 ex_rs_data/ex_rt_data  out  32/32, ex_imm  out  32, ex_dest  out  5, ex_we  out  1, ex_opcode  out  6, ex_funct  out  6, ex_shamt  out  5, ex_pc  out  32, ex_illegal  out  1.
REQ-010 No parameters.

Function
REQ-011 Two registers: hold slot (instr+pc+hold_valid) and output slot (ex_*); plus 32-bit scoreboard pend[31:0].
REQ-012 if_ready = ~hold_valid | issue; fetch transfer when if_valid & if_ready.
REQ-013 rf_read1 = hold rs [25:21], rf_read2 = hold rt [20:16], combinational from hold slot.
REQ-014 Decode: opcode 0x00 -> dest rd, we=1; 0x08/09/0A/0C/0D/0E/0F/23 -> dest rt, we=1; 0x2B/04/05 -> we=0, reads rs,rt; 0x02 -> we=0, no reads; other -> ex_illegal=1, we=0, no reads.
REQ-015 ex_imm: zero-extend imm16 for 0x0C/0D/0E; imm16<<16 for 0x0F; sign-extend otherwise.
REQ-016 Dest id 0 SHALL force we=0 and never set pend[0].
REQ-017 Hazard = any used source s with pend[s] & ~(wb_we & wb_id==s), or we & pend[dest] & ~(wb_we & wb_id==dest) (WAW).
REQ-018 issue = hold_valid & ~hazard & (~ex_valid | ex_ready) & ~flush.
REQ-019 Operand bypass: source equal to wb_id with wb_we & wb_id!=0 takes wb_data, else rf_data; source 0 always 0.
REQ-020 On issue: output slot loads decoded fields, ex_valid=1, pend[dest] set if we.
REQ-021 ex_valid & ex_ready & ~issue -> ex_valid=0; output slot held stable while ex_valid & ~ex_ready.
REQ-022 wb_we clears pend[wb_id]; same-cycle set (issue) and clear of same id -> set wins.
REQ-023 Latency: instruction accepted at edge k appears with ex_valid after edge k+1 when no hazard/backpressure; throughput 1/cycle.
REQ-024 flush: hold_valid=0, ex_valid=0 if not accepted that cycle, pend bit of discarded output-slot dest cleared; if_ready=0 that cycle; other pend bits unchanged.
REQ-025 Hold-slot FSM: EMPTY->FULL on fetch; FULL->FULL on issue+fetch; FULL->EMPTY on issue without fetch or flush; FULL stays on hazard/backpressure.

Reset
REQ-026 Reset low SHALL asynchronously clear hold_valid, ex_valid, ex_we, ex_illegal, pend, and all ex_* data to 0; if_ready=1 after release.
REQ-027 Reset mid-operation discards all instructions; no partial issue.

Verification
REQ-028 addi $1,$0,5 (0x20010005), ex_ready=1 -> ex_valid after edge k+1, ex_dest=1, ex_imm=5, pend[1]=1.
REQ-029 addi $1 then add $2,$1,$1 with no wb -> second stalls, if_ready=0; wb_we=1,wb_id=1,wb_data=7 -> issues next edge, ex_rs_data=ex_rt_data=7.
REQ-030 ori $3,$0,0x8000 -> ex_imm=0x00008000; lw offset 0x8000 -> ex_imm=0xFFFF8000; lui 0x1234 -> 0x12340000.
REQ-031 ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* stable, second instruction held, if_ready=0.
REQ-032 flush with add $4 in output slot -> ex_valid=0, pend[4]=0; opcode 0x3F -> ex_illegal=1, ex_we=0.
REQ-033 Assert rst_n low mid-stall -> ex_valid, pend cleared immediately without clock.
